// File: rtl/sub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial subtract sequencer.
// Holds the FSM state encoding and the width of one arithmetic slice.
package sub_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  // Encoding 2'd3 is never entered; the FSM treats it as a fault and returns to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_sub_stage.sv
// 4-bit combinational ripple-borrow subtract stage: {bout, d4} = a4 - b4 - bin.
// Built bit by bit so the borrow chain is explicit.
module nibble_sub_stage
  import sub_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d4,
  output logic                bout
);

  logic [NIBBLE_W:0] br;

  always_comb begin
    br[0] = bin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      d4[i]   = a4[i] ^ b4[i] ^ br[i];
      // Borrow out when a<b at this bit, or the bits are equal and a borrow is pending.
      br[i+1] = (~a4[i] & b4[i]) | (~(a4[i] ^ b4[i]) & br[i]);
    end
    bout = br[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Wide subtraction a - b - borrow_in computed one nibble per clock, LSB first,
// through a single shared 4-bit stage, with valid/ready command and result sides.
module nibble_serial_sub_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES,
  localparam int IDX_W   = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic         busy,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [W-1:0] diff,
  output logic         borrow_out,
  output logic         zero
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [W-1:0]       diff_q, diff_d;
  logic               borrow_out_q, borrow_out_d;
  logic               zero_q, zero_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, d_nib;
  logic                stage_bout;
  logic [W-1:0]        diff_upd;
  logic                last_nib;

  nibble_sub_stage u_stage (
    .a4   (a_nib),
    .b4   (b_nib),
    .bin  (borrow_q),
    .d4   (d_nib),
    .bout (stage_bout)
  );

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    a_nib    = '0;
    b_nib    = '0;
    diff_upd = diff_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib                          = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib                          = b_q[i*NIBBLE_W +: NIBBLE_W];
        diff_upd[i*NIBBLE_W +: NIBBLE_W] = d_nib;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d  = ST_RUN;
          a_d      = a;
          b_d      = b;
          borrow_d = borrow_in;
          idx_d    = '0;
        end
      end
      ST_RUN: begin
        diff_d   = diff_upd;
        borrow_d = stage_bout;
        if (last_nib) begin
          // zero looks at the merged word so the final nibble is included.
          state_d      = ST_DONE;
          borrow_out_d = stage_bout;
          zero_d       = (diff_upd == '0);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, matching the hardware it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the result registers are cleared too, so an aborted operation
      // never leaves a partial difference visible after reset.
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign result_valid = (state_q == ST_DONE);
  assign diff         = diff_q;
  assign borrow_out   = borrow_out_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Scoreboard bench for nibble_serial_sub_ctrl: the driver pushes expected results
// computed with plain wide arithmetic; an independent monitor pops and compares.
module tb_nibble_serial_sub_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         zero;

  nibble_serial_sub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .borrow_in    (borrow_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .diff         (diff),
    .borrow_out   (borrow_out),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         z;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ready_mode = 0;  // 0: always ready, 1: hold off, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Consumer side: ready changes just after each rising edge.
  initial begin
    result_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       result_ready = 1'b1;
        1:       result_ready = 1'b0;
        default: result_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compares each new result, then checks it holds until the handshake.
  logic         prev_valid = 1'b0;
  logic         prev_hs    = 1'b0;
  logic [W-1:0] held_diff;
  logic         held_bo, held_z;
  exp_t         e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (result_valid) begin
          if (prev_valid && !prev_hs) begin
            check("hold_diff", 32'(diff), 32'(held_diff));
            check("hold_borrow", 32'(borrow_out), 32'(held_bo));
            check("hold_zero", 32'(zero), 32'(held_z));
          end else if (sb_q.size() == 0) begin
            check("unexpected_result", 32'(1), 32'(0));
          end else begin
            e = sb_q[0];
            check("diff", 32'(diff), 32'(e.diff));
            check("borrow_out", 32'(borrow_out), 32'(e.bo));
            check("zero", 32'(zero), 32'(e.z));
            // Accept edge plus NIBBLES further edges: NIBBLES+1 edges in all.
            check("latency", 32'(cyc - e.acc_cyc), 32'(NIBBLES));
          end
          if (result_ready && sb_q.size() > 0) void'(sb_q.pop_front());
          held_diff = diff;
          held_bo   = borrow_out;
          held_z    = zero;
          prev_hs   = result_ready;
        end
        prev_valid = result_valid;
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tbin, input int gap);
    exp_t         x;
    logic [W:0]   full;
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1;
    a           = ta;
    b           = tb_v;
    borrow_in   = tbin;
    start_valid = 1'b1;
    full      = {1'b0, ta} - {1'b0, tb_v} - {{W{1'b0}}, tbin};
    x.diff    = full[W-1:0];
    x.bo      = ({1'b0, ta} < ({1'b0, tb_v} + {{W{1'b0}}, tbin}));
    x.z       = (x.diff == '0);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (start_ready) begin
        x.acc_cyc = cyc + 1;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'(0), 32'(1));
    start_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && start_ready) return;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    a           = '0;
    b           = '0;
    borrow_in   = 1'b0;

    #3;
    check("rst_start_ready", 32'(start_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_result_valid", 32'(result_valid), 32'(0));
    check("rst_diff", 32'(diff), 32'(0));
    check("rst_borrow_out", 32'(borrow_out), 32'(0));
    check("rst_zero", 32'(zero), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors: basic, full borrow ripple, borrow_in, zero result.
    issue(16'h1234, 16'h0234, 1'b0, 0); wait_idle();
    issue(16'h0000, 16'h0001, 1'b0, 0); wait_idle();
    issue(16'h0010, 16'h0000, 1'b1, 0); wait_idle();
    issue(16'hABCD, 16'hABCD, 1'b0, 0); wait_idle();
    issue(16'h0000, 16'hFFFF, 1'b1, 1); wait_idle();

    // Backpressure: result must hold and new commands must be refused.
    ready_mode = 1;
    issue(16'h4321, 16'h1111, 1'b0, 0);
    for (int n = 0; n < 50 && !result_valid; n++) @(negedge clk);
    check("bp_reached_done", 32'(result_valid), 32'(1));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_start_ready", 32'(start_ready), 32'(0));
      check("bp_result_valid", 32'(result_valid), 32'(1));
      start_valid = k[0];
      a           = W'($urandom);
      b           = W'($urandom);
    end
    @(negedge clk);
    start_valid = 1'b0;
    ready_mode  = 0;
    for (int n = 0; n < 20 && result_valid; n++) @(negedge clk);
    check("bp_release_valid", 32'(result_valid), 32'(0));
    check("bp_release_start_ready", 32'(start_ready), 32'(1));
    wait_idle();

    // Reset while the third nibble is being processed aborts the operation.
    issue(16'h7777, 16'h1111, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_result_valid", 32'(result_valid), 32'(0));
    check("abort_diff", 32'(diff), 32'(0));
    check("abort_start_ready", 32'(start_ready), 32'(1));
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h0005, 16'h0003, 1'b0, 0); wait_idle();

    // Random traffic with random command gaps and consumer stalls.
    ready_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i % 8 == 0) ? ra : W'($urandom);
      issue(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
